// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// access FSM states and small address-alignment helpers.
package mem_stage_pkg;

  // in_data_size encodings; 2'b11 is reserved and behaves like a word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Access FSM: idle / request held until grant / waiting for read data
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // True when the byte offset is not naturally aligned for the access size
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Forces the low offset bits to the natural alignment of the access size
  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] off);
    logic [1:0] aligned;
    case (size)
      SIZE_BYTE: aligned = off;
      SIZE_HALF: aligned = {off[1], 1'b0};
      SIZE_WORD: aligned = 2'b00;
      default:   aligned = 2'b00;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory
// (slave): req/gnt request handshake plus rvalid-qualified read data.
interface mem_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);

  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [WORD_SIZE-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the MEM stage. Purely combinational: turns access
// size and byte offset into byte enables, lane-replicated store data, and
// the selected, sign- or zero-extended load value. The offset is expected
// to be already aligned for the access size.
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [1:0]           size,
  input  logic                 sign,
  input  logic [1:0]           offset,
  input  logic [WORD_SIZE-1:0] store_data,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [3:0]           be,
  output logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] load_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Split the read word into its four byte lanes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  // Lane select, byte enables, store replication and load extension
  always_comb begin
    sel_byte  = rd_byte[offset];
    sel_half  = offset[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{(WORD_SIZE-8){sign & sel_byte[7]}}, sel_byte};
      end
      SIZE_HALF: begin
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{(WORD_SIZE-16){sign & sel_half[15]}}, sel_half};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V pipeline. Non-memory instructions pass
// their ALU result to MEM/WB in one edge; loads and stores are latched and
// run on the data-memory bus (IDLE -> REQ -> [WAIT] -> IDLE) while the rest
// of the pipeline is stalled. Also drives the MEM->EX forwarding path.
// Optional feature macro: MEM_MISALIGN_TRAP_EN adds the misaligned trap
// output; without it misaligned addresses are silently aligned down.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  // EX/MEM register contents
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_addr,
  input  logic [WORD_SIZE-1:0] in_store_data,
  input  logic [1:0]           in_data_size,
  input  logic                 in_data_sign,
  input  logic [REG_SEL-1:0]   in_rd,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic                 in_reg_write,
  output logic                 stall,
  // data-memory bus
  mem_stage_if.master          dmem,
  // MEM/WB register
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic [REG_SEL-1:0]   wb_rd,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 misaligned,
`endif
  // forwarding back into EX
  output logic [WORD_SIZE-1:0] mem_fwd_data,
  output logic [REG_SEL-1:0]   mem_fwd_rd
);

  // FSM state and access latch
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
  logic [3:0]           be_q, be_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [1:0]           size_q, size_d;
  logic                 sign_q, sign_d;
  logic [1:0]           off_q, off_d;
  logic [REG_SEL-1:0]   rd_q, rd_d;
  logic                 reg_write_q, reg_write_d;
  logic                 we_q, we_d;

  // MEM/WB register
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic [REG_SEL-1:0]   wb_rd_q, wb_rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                 misaligned_q, misaligned_d;
`endif

  // Lane steering: in IDLE it shapes the incoming store, afterwards it
  // extracts load data using the latched size/offset.
  logic                 idle;
  logic [1:0]           lsu_size;
  logic [1:0]           lsu_offset;
  logic [3:0]           lsu_be;
  logic [WORD_SIZE-1:0] lsu_wdata;
  logic [WORD_SIZE-1:0] lsu_load_data;
  logic                 mem_op;
  logic                 trap;

  assign idle       = (state_q == ST_IDLE);
  assign lsu_size   = idle ? in_data_size : size_q;
  assign lsu_offset = idle ? align_offset(in_data_size, in_addr[1:0]) : off_q;
  assign mem_op     = in_mem_read | in_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(in_data_size, in_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_align #(
    .WORD_SIZE (WORD_SIZE)
  ) u_lsu_align (
    .size       (lsu_size),
    .sign       (sign_q),
    .offset     (lsu_offset),
    .store_data (in_store_data),
    .rdata      (dmem.rdata),
    .be         (lsu_be),
    .wdata      (lsu_wdata),
    .load_data  (lsu_load_data)
  );

  // Next state, access latch, MEM/WB values and stall for the access FSM
  always_comb begin
    state_d        = state_q;
    waddr_d        = waddr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    size_d         = size_q;
    sign_d         = sign_q;
    off_d          = off_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    we_d           = we_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned_d   = 1'b0;
`endif
    stall          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            // ALU result goes straight through
            wb_valid_d     = 1'b1;
            wb_reg_write_d = in_reg_write;
            wb_data_d      = in_addr;
            wb_rd_d        = in_rd;
          end else if (trap) begin
            // Misaligned access: retire without touching memory
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_data_d      = in_addr;
            wb_rd_d        = in_rd;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_d   = 1'b1;
`endif
          end else begin
            // Capture the access; a write flag wins if both are set
            stall       = 1'b1;
            state_d     = ST_REQ;
            waddr_d     = in_addr[ADDR_SIZE+1:2];
            be_d        = lsu_be;
            wdata_d     = lsu_wdata;
            size_d      = in_data_size;
            sign_d      = in_data_sign;
            off_d       = lsu_offset;
            rd_d        = in_rd;
            reg_write_d = in_reg_write;
            we_d        = in_mem_write;
          end
        end
      end

      ST_REQ: begin
        stall = 1'b1;
        if (dmem.gnt) begin
          if (we_q) begin
            stall          = 1'b0;
            state_d        = ST_IDLE;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = rd_q;
          end else if (dmem.rvalid) begin
            // Zero-wait memory: grant and data in the same cycle
            stall          = 1'b0;
            state_d        = ST_IDLE;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = reg_write_q;
            wb_data_d      = lsu_load_data;
            wb_rd_d        = rd_q;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        stall = 1'b1;
        if (dmem.rvalid) begin
          stall          = 1'b0;
          state_d        = ST_IDLE;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = reg_write_q;
          wb_data_d      = lsu_load_data;
          wb_rd_d        = rd_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, access latch and MEM/WB register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      waddr_q        <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      size_q         <= '0;
      sign_q         <= 1'b0;
      off_q          <= '0;
      rd_q           <= '0;
      reg_write_q    <= 1'b0;
      we_q           <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      waddr_q        <= waddr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      size_q         <= size_d;
      sign_q         <= sign_d;
      off_q          <= off_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      we_q           <= we_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q   <= misaligned_d;
`endif
    end
  end

  // Bus outputs come straight from the latch so they stay stable in REQ
  assign dmem.req   = (state_q == ST_REQ);
  assign dmem.we    = (state_q == ST_REQ) & we_q;
  assign dmem.addr  = waddr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned   = misaligned_q;
`endif

  // Loads cannot forward from MEM: their data is not known yet
  assign mem_fwd_data = in_addr;
  assign mem_fwd_rd   = (in_valid & in_reg_write & ~in_mem_read) ? in_rd : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single transactions driven in
// a loop, scoreboard for MEM/WB results, and hand sequences for reset
// during an access and for the misaligned-address behaviour.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [31:0] JUNK = 32'h5A5A_C3C3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [1:0]  in_data_size;
  logic        in_data_sign;
  logic [4:0]  in_rd;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] mem_fwd_data;
  logic [4:0]  mem_fwd_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  mem_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) dmem_bus ();

  mem_stage #(
    .WORD_SIZE (32),
    .NUM_REGS  (32),
    .ADDR_SIZE (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .in_data_size  (in_data_size),
    .in_data_sign  (in_data_sign),
    .in_rd         (in_rd),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_reg_write  (in_reg_write),
    .stall         (stall),
    .dmem          (dmem_bus),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned    (misaligned),
`endif
    .mem_fwd_data  (mem_fwd_data),
    .mem_fwd_rd    (mem_fwd_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        is_ld;
    logic        is_st;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    int          gnt_dly;
    int          rv_dly;
    logic [9:0]  exp_waddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    logic        chk_rd;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_ld, input logic is_st, input logic [1:0] size,
                              input logic sign, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                              input int gnt_dly, input int rv_dly, input logic [9:0] exp_waddr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_data);
    vec_t v;
    v.is_ld = is_ld;  v.is_st = is_st;  v.size = size;  v.sign = sign;
    v.addr = addr;    v.sdata = sdata;  v.rdata = rdata;
    v.rd = rd;        v.rw = rw;        v.gnt_dly = gnt_dly;  v.rv_dly = rv_dly;
    v.exp_waddr = exp_waddr;  v.exp_be = exp_be;
    v.exp_wdata = exp_wdata;  v.exp_data = exp_data;
    return v;
  endfunction

  // Scoreboard: every MEM/WB result must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL wb_unexpected: got wb_valid=1 data=%h expected no result", wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
        if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
        if (mon_e.chk_rd)   chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misaligned_flag", 32'(misaligned), 32'(mon_e.mis));
`endif
      end
    end
`ifdef MEM_MISALIGN_TRAP_EN
    if (!rst && misaligned && !wb_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL misaligned_alone: got misaligned=1 expected wb_valid with it");
    end
`endif
  end

  task automatic idle_inputs();
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_reg_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    logic mem;
    logic done;
    mem = v.is_ld | v.is_st;
    @(posedge clk); #1;
    in_valid      = 1'b1;
    in_addr       = v.addr;
    in_store_data = v.sdata;
    in_data_size  = v.size;
    in_data_sign  = v.sign;
    in_rd         = v.rd;
    in_mem_read   = v.is_ld;
    in_mem_write  = v.is_st;
    in_reg_write  = v.rw;
    e.chk_data = ~v.is_st;
    e.data     = v.exp_data;
    e.chk_rd   = ~v.is_st;
    e.rd       = v.rd;
    e.rw       = v.is_st ? 1'b0 : v.rw;
    e.mis      = 1'b0;
    sb.push_back(e);
    $display("[TB] txn %0d: ld=%0d st=%0d size=%0d addr=%h gnt_dly=%0d rv_dly=%0d",
             idx, v.is_ld, v.is_st, v.size, v.addr, v.gnt_dly, v.rv_dly);
    @(negedge clk);
    chk("fwd_data", mem_fwd_data, v.addr);
    chk("fwd_rd", 32'(mem_fwd_rd), (v.rw && !v.is_ld) ? 32'(v.rd) : 32'd0);
    chk("accept_stall", 32'(stall), 32'(mem));
    if (!mem) begin
      chk("alu_no_req", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
    end else begin
      @(posedge clk); #1;
      for (int i = 0; i <= v.gnt_dly; i++) begin
        done = 1'b0;
        if (i == v.gnt_dly) begin
          dmem_bus.gnt = 1'b1;
          if (v.is_ld && v.rv_dly == 0) begin
            dmem_bus.rvalid = 1'b1;
            dmem_bus.rdata  = v.rdata;
          end
          done = v.is_st || (v.rv_dly == 0);
        end
        @(negedge clk);
        chk("req", 32'(dmem_bus.req), 32'd1);
        chk("we", 32'(dmem_bus.we), 32'(v.is_st));
        chk("dmem_addr", 32'(dmem_bus.addr), 32'(v.exp_waddr));
        chk("be", 32'(dmem_bus.be), 32'(v.exp_be));
        if (v.is_st) chk("wdata", dmem_bus.wdata, v.exp_wdata);
        chk("req_stall", 32'(stall), 32'(!done));
        @(posedge clk); #1;
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = JUNK;
      end
      if (v.is_ld && v.rv_dly > 0) begin
        for (int j = 1; j <= v.rv_dly; j++) begin
          if (j == v.rv_dly) begin
            dmem_bus.rvalid = 1'b1;
            dmem_bus.rdata  = v.rdata;
          end
          @(negedge clk);
          chk("wait_no_req", 32'(dmem_bus.req), 32'd0);
          chk("wait_stall", 32'(stall), 32'(j != v.rv_dly));
          @(posedge clk); #1;
          dmem_bus.rvalid = 1'b0;
          dmem_bus.rdata  = JUNK;
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // is_ld is_st size sign addr sdata rdata rd rw gnt rv waddr be wdata data
    vecs.push_back(mk(0, 0, SIZE_WORD, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 0, 0, 10'h0, 4'h0, 32'h0, 32'h0000_1234));
    vecs.push_back(mk(0, 0, SIZE_WORD, 0, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd31, 0, 0, 0, 10'h0, 4'h0, 32'h0, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 1, SIZE_BYTE, 0, 32'h0000_0006, 32'h1234_56A5, 32'h0, 5'd0, 0, 0, 0, 10'h001, 4'b0100, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mk(0, 1, SIZE_HALF, 0, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0, 5'd6, 1, 2, 0, 10'h040, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    vecs.push_back(mk(0, 1, SIZE_WORD, 0, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0, 5'd8, 0, 1, 0, 10'h3FF, 4'b1111, 32'h0BAD_F00D, 32'h0));
    vecs.push_back(mk(1, 0, SIZE_HALF, 1, 32'h0000_0002, 32'h0, 32'h8001_0000, 5'd7, 1, 0, 3, 10'h000, 4'b1100, 32'h0, 32'hFFFF_8001));
    vecs.push_back(mk(1, 0, SIZE_BYTE, 0, 32'h0000_0003, 32'h0, 32'hF000_0000, 5'd9, 1, 0, 0, 10'h000, 4'b1000, 32'h0, 32'h0000_00F0));
    vecs.push_back(mk(1, 0, SIZE_BYTE, 1, 32'h0000_0001, 32'h0, 32'h0000_8000, 5'd10, 1, 1, 1, 10'h000, 4'b0010, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, SIZE_HALF, 0, 32'h0000_0008, 32'h0, 32'h1234_9ABC, 5'd11, 1, 0, 2, 10'h002, 4'b0011, 32'h0, 32'h0000_9ABC));
    vecs.push_back(mk(1, 0, SIZE_WORD, 1, 32'h0000_0010, 32'h0, 32'h8765_4321, 5'd12, 1, 0, 1, 10'h004, 4'b1111, 32'h0, 32'h8765_4321));
    vecs.push_back(mk(1, 0, SIZE_WORD, 0, 32'h0000_0020, 32'h0, 32'h0000_0055, 5'd0, 1, 0, 0, 10'h008, 4'b1111, 32'h0, 32'h0000_0055));
    vecs.push_back(mk(1, 0, SIZE_BYTE, 1, 32'h0000_0002, 32'h0, 32'h007F_0000, 5'd13, 1, 0, 0, 10'h000, 4'b0100, 32'h0, 32'h0000_007F));
    vecs.push_back(mk(1, 0, 2'b11,     1, 32'h0000_0004, 32'h0, 32'hA5A5_5A5A, 5'd14, 1, 0, 0, 10'h001, 4'b1111, 32'h0, 32'hA5A5_5A5A));
`ifndef MEM_MISALIGN_TRAP_EN
    // Misaligned addresses are aligned down when the trap is not built in
    vecs.push_back(mk(1, 0, SIZE_WORD, 0, 32'h0000_0005, 32'h0, 32'h1357_2468, 5'd15, 1, 0, 0, 10'h001, 4'b1111, 32'h0, 32'h1357_2468));
    vecs.push_back(mk(0, 1, SIZE_HALF, 0, 32'h0000_0003, 32'h0000_CDEF, 32'h0, 5'd0, 0, 0, 0, 10'h000, 4'b1100, 32'hCDEF_CDEF, 32'h0));
`endif

    rst             = 1'b1;
    in_addr         = '0;
    in_store_data   = '0;
    in_data_size    = '0;
    in_data_sign    = 1'b0;
    in_rd           = '0;
    idle_inputs();
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = JUNK;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_we", 32'(dmem_bus.we), 32'd0);
    chk("rst_be", 32'(dmem_bus.be), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif

    // rvalid while idle must not produce a result
    @(posedge clk); #1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h1111_2222;
    @(posedge clk); #1;
    dmem_bus.rvalid = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_ignored", 32'(wb_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while waiting for load data; the late rvalid must be dropped
    @(posedge clk); #1;
    $display("[TB] txn rst_in_wait: word load at 0x40");
    in_valid     = 1'b1;
    in_addr      = 32'h0000_0040;
    in_data_size = SIZE_WORD;
    in_data_sign = 1'b0;
    in_rd        = 5'd3;
    in_mem_read  = 1'b1;
    in_reg_write = 1'b1;
    @(posedge clk); #1;
    dmem_bus.gnt = 1'b1;
    @(posedge clk); #1;
    dmem_bus.gnt = 1'b0;
    @(negedge clk);
    chk("wait_state_stall", 32'(stall), 32'd1);
    chk("wait_state_req", 32'(dmem_bus.req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_req", 32'(dmem_bus.req), 32'd0);
    chk("rst_wait_stall", 32'(stall), 32'd0);
    chk("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h7777_8888;
    @(posedge clk); #1;
    dmem_bus.rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_rvalid_wb_data", wb_data, 32'd0);
    chk("late_rvalid_req", 32'(dmem_bus.req), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without a bus request or stall
    begin
      exp_t e;
      @(posedge clk); #1;
      $display("[TB] txn misaligned: word load at 0x5");
      in_valid     = 1'b1;
      in_addr      = 32'h0000_0005;
      in_data_size = SIZE_WORD;
      in_rd        = 5'd4;
      in_mem_read  = 1'b1;
      in_reg_write = 1'b1;
      e.chk_data = 1'b0;  e.data = 32'h0;
      e.chk_rd   = 1'b0;  e.rd   = 5'd0;
      e.rw       = 1'b0;  e.mis  = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_no_req", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("mis_pulse", 32'(misaligned), 32'd1);
      chk("mis_no_req_after", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_pulse_end", 32'(misaligned), 32'd0);
    end
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
